// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM encoding and iteration counter sizing.
package seq_divider_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 2N, the number of quotient bits to produce.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the multiplier datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_divider_sub_step.sv
// Combinational (N+1)-bit trial subtract T = S - D built as a ripple of
// full adders adding ~D with carry-in 1; borrow is the inverted carry-out.
module div_sub_step #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] s,
  input  logic [W-2:0] d,
  output logic [W-1:0] t,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] d_inv;

  assign carry[0] = 1'b1;
  assign d_inv    = ~{1'b0, d};

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a    (s[i]),
      .b    (d_inv[i]),
      .cin  (carry[i]),
      .sum  (t[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = cnt_width(N);

  state_t        state;
  logic [W2-1:0] q_reg;
  logic [N-1:0]  d_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] count;

  logic [N:0]    s;
  logic [N:0]    t;
  logic          borrow;
  logic [N:0]    r_next;
  logic [W2-1:0] q_next;

  // R < D always holds, so the top bit of R is structurally zero.
  logic unused_r_msb;
  assign unused_r_msb = r_reg[N];

  assign s = {r_reg[N-1:0], q_reg[W2-1]};

  div_sub_step #(
    .W (N + 1)
  ) u_sub (
    .s      (s),
    .d      (d_reg),
    .t      (t),
    .borrow (borrow)
  );

  // Restore on borrow, otherwise keep the difference and shift in a 1.
  always_comb begin
    r_next = t;
    q_next = {q_reg[W2-2:0], 1'b1};
    if (borrow) begin
      r_next = s;
      q_next = {q_reg[W2-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg    <= dividend;
            d_reg    <= divisor;
            r_reg    <= '0;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              count     <= '0;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[N-1:0];
              div_zero  <= 1'b1;
            end else begin
              state <= RUN;
              count <= CW'(W2);
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[N-1:0];
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an integer division model.
module tb_seq_divider;

  localparam int unsigned N  = 4;
  localparam int unsigned W2 = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W2-1:0] dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W2-1:0] quotient;
  logic [N-1:0]  remainder;
  logic          div_zero;

  int checks = 0;
  int passed = 0;

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division, zero divisor gives all-ones / low dividend bits.
  function automatic logic [W2+N:0] ref_div(input int unsigned a, input int unsigned b);
    logic [W2-1:0] q;
    logic [N-1:0]  r;
    logic          z;
    if (b == 0) begin
      q = '1;
      r = N'(a % (1 << N));
      z = 1'b1;
    end else begin
      q = W2'(a / b);
      r = N'(a % b);
      z = 1'b0;
    end
    return {q, r, z};
  endfunction

  // Drive one operand pair through an accept edge; DUT must be idle.
  task automatic start_op(input logic [W2-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = W2'($urandom);
    divisor  = N'($urandom);
  endtask

  // Edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h z=%b, want rdy=1 vld=0 q=00 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_zero);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W2-1:0] ta [4] = '{8'd200, 8'd255, 8'd0, 8'd37};
    logic [N-1:0]  tb [4] = '{4'd7, 4'd1, 4'd15, 4'd0};
    for (int i = 0; i < 4; i++) begin
      logic [W2+N:0] exp_v;
      int lat;
      exp_v = ref_div(int'(ta[i]), int'(tb[i]));
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      checks++;
      if (lat != ((tb[i] == 0) ? 1 : 9))
        $display("FAIL latency %0d/%0d: got %0d, want %0d", ta[i], tb[i], lat, (tb[i] == 0) ? 1 : 9);
      else passed++;
      checks++;
      if ({quotient, remainder, div_zero} !== exp_v)
        $display("FAIL result %0d/%0d: q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", ta[i], tb[i],
                 quotient, remainder, div_zero, exp_v[W2+N:N+1], exp_v[N:1], exp_v[0]);
      else passed++;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL busy_ready: in_ready=%b, want 0", in_ready);
      else passed++;
      handoff();
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL after_handoff: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int lat;
    start_op(8'd225, 4'd15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'd3;
      divisor  = 4'd1;
    end
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'd15, 4'd0, 1'b0})
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b q=%0d r=%0d z=%b, want vld=1 rdy=0 q=15 r=0 z=0",
                 i, out_valid, in_ready, quotient, remainder, div_zero);
      else passed++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    handoff();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL stall_release: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    start_op(8'd200, 4'd7);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset_mid: rdy=%b vld=%b q=%h r=%h z=%b, want rdy=1 vld=0 q=00 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_zero);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen != 0) $display("FAIL reset_no_pulse: out_valid seen %0d cycles, want 0", seen);
    else passed++;
    start_op(8'd100, 4'd9);
    wait_valid(lat);
    checks++;
    if ({quotient, remainder, div_zero} !== {8'd11, 4'd1, 1'b0})
      $display("FAIL post_reset_op: q=%0d r=%0d z=%b, want q=11 r=1 z=0", quotient, remainder, div_zero);
    else passed++;
    handoff();
  endtask

  task automatic test_exhaustive();
    logic [W2+N:0] exp_q[$];
    int results = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        int lat;
        logic [W2+N:0] exp_v;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start_op(W2'(a), N'(b));
        exp_q.push_back(ref_div(a, b));
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
          in_valid = 1'($urandom_range(0, 1));
          dividend = W2'($urandom);
          divisor  = N'($urandom);
          @(negedge clk);
          lat++;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (!out_valid || {quotient, remainder, div_zero} !== exp_v)
          $display("FAIL exhaustive %0d/%0d: vld=%b q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b", a, b,
                   out_valid, quotient, remainder, div_zero, exp_v[W2+N:N+1], exp_v[N:1], exp_v[0]);
        else passed++;
        handoff();
        if (out_valid) $display("FAIL exhaustive_dup %0d/%0d: out_valid still high after handoff", a, b);
        else results++;
      end
    end
    checks++;
    if (results != 4096) $display("FAIL exhaustive_count: got %0d clean handoffs, want 4096", results);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid_run();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
